// File: rtl/pytxacl_pingpong_ctrl_if.sv
// Handshake/bus bundle between the ping-pong TX ACL controller and its bsm/lnctrl/datapath neighbours.
interface pytxacl_pingpong_ctrl_if;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned ADDR_W = 8;

    logic              bsm_wr_done;
    logic [LEN_W-1:0]  bsm_wr_len;
    logic              bsm_wr_ready;
    logic              s1a;
    logic              tx_req;
    logic [LEN_W-1:0]  tx_len;
    logic              tx_seqn;
    logic              tx_start;
    logic              tx_word_rd;
    logic              tx_end;
    logic              arqn_valid;
    logic              arqn;
    logic              flush;
    logic [ADDR_W-1:0] lnctrl_addr;
    logic              lnctrl_cs;

    modport master (
        output bsm_wr_done, bsm_wr_len, tx_start, tx_word_rd, tx_end,
               arqn_valid, arqn, flush,
        input  bsm_wr_ready, s1a, tx_req, tx_len, tx_seqn, lnctrl_addr, lnctrl_cs
    );

    modport slave (
        input  bsm_wr_done, bsm_wr_len, tx_start, tx_word_rd, tx_end,
               arqn_valid, arqn, flush,
        output bsm_wr_ready, s1a, tx_req, tx_len, tx_seqn, lnctrl_addr, lnctrl_cs
    );
endinterface

// File: rtl/pytxacl_pingpong_ctrl.sv
// Ping-pong TX ACL buffer controller: bank swapping, lnctrl read addressing and ACL ARQ (ACK/NAK) handling.
module pytxacl_pingpong_ctrl (
    input logic                     clk_6M,
    input logic                     rstz,
    pytxacl_pingpong_ctrl_if.slave  bus
);
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WCNT_W = 9;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TX        = 2'd1,
        S_WAIT_ARQN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                s1a_q, s1a_d;
    logic                seqn_q, seqn_d;
    logic [1:0]          full_q, full_d;
    logic [LEN_W-1:0]    len0_q, len0_d;
    logic [LEN_W-1:0]    len1_q, len1_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;

    logic                wr_bank;
    logic                rd_bank;
    logic [LEN_W-1:0]    rd_len;
    logic [LEN_W:0]      rd_len_p3;
    logic [WCNT_W-1:0]   nwords;
    logic                tx_req_c;

    // s1a = 1 puts bsm on bank 0 and lnctrl on bank 1
    assign wr_bank   = ~s1a_q;
    assign rd_bank   = s1a_q;
    assign rd_len    = s1a_q ? len1_q : len0_q;
    assign rd_len_p3 = {1'b0, rd_len} + (LEN_W+1)'(3);
    assign nwords    = WCNT_W'(rd_len_p3 >> 2);
    assign tx_req_c  = full_q[rd_bank] & (state_q != S_WAIT_ARQN);

    assign bus.bsm_wr_ready = ~full_q[wr_bank];
    assign bus.s1a          = s1a_q;
    assign bus.tx_req       = tx_req_c;
    assign bus.tx_len       = rd_len;
    assign bus.tx_seqn      = seqn_q;
    assign bus.lnctrl_addr  = addr_q;
    assign bus.lnctrl_cs    = cs_q;

    // Next-state: flush overrides everything else in the same cycle
    always_comb begin
        state_d = state_q;
        s1a_d   = s1a_q;
        seqn_d  = seqn_q;
        full_d  = full_q;
        len0_d  = len0_q;
        len1_d  = len1_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        cs_d    = 1'b0;

        if (bus.flush) begin
            if (full_q[rd_bank]) begin
                seqn_d = ~seqn_q;
            end
            full_d  = 2'b00;
            state_d = S_IDLE;
        end else begin
            if (bus.bsm_wr_done && !full_q[wr_bank]) begin
                full_d[wr_bank] = 1'b1;
                if (wr_bank) begin
                    len1_d = bus.bsm_wr_len;
                end else begin
                    len0_d = bus.bsm_wr_len;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    // A swap and a tx_start can never coincide: swap needs the read bank empty
                    if (full_q[wr_bank] && !full_q[rd_bank]) begin
                        s1a_d = ~s1a_q;
                    end else if (bus.tx_start && tx_req_c) begin
                        state_d = S_TX;
                        wcnt_d  = '0;
                    end
                end
                S_TX: begin
                    if (bus.tx_word_rd && (wcnt_q < nwords)) begin
                        cs_d   = 1'b1;
                        addr_d = ADDR_W'(wcnt_q);
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                    if (bus.tx_end) begin
                        state_d = S_WAIT_ARQN;
                    end
                end
                S_WAIT_ARQN: begin
                    if (bus.arqn_valid) begin
                        if (bus.arqn) begin
                            full_d[rd_bank] = 1'b0;
                            seqn_d          = ~seqn_q;
                        end
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= S_IDLE;
            s1a_q   <= 1'b1;
            seqn_q  <= 1'b1;
            full_q  <= 2'b00;
            len0_q  <= '0;
            len1_q  <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s1a_q   <= s1a_d;
            seqn_q  <= seqn_d;
            full_q  <= full_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
        end
    end
endmodule

// File: tb/tb_pytxacl_pingpong_ctrl.sv
// Bench for pytxacl_pingpong_ctrl: table of per-cycle vectors plus a scoreboard for lnctrl read strobes.
module tb_pytxacl_pingpong_ctrl;
    localparam int WD = 1;
    localparam int ST = 2;
    localparam int RD = 4;
    localparam int EN = 8;
    localparam int AV = 16;
    localparam int AK = 32;
    localparam int FL = 64;

    typedef struct {
        int ev;
        int len;
        int addr;
        int s1a;
        int req;
        int tlen;
        int seqn;
        int rdy;
    } vec_t;

    typedef struct {
        int addr;
        int due;
    } exp_t;

    logic clk_6M;
    logic rstz;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    exp_t sb[$];

    pytxacl_pingpong_ctrl_if bus ();

    pytxacl_pingpong_ctrl dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus.slave)
    );

    initial clk_6M = 1'b0;
    always #5 clk_6M = ~clk_6M;
    always @(posedge clk_6M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic drive(input int ev, input int len);
        bus.bsm_wr_done = (ev & WD) != 0;
        bus.bsm_wr_len  = 10'(len);
        bus.tx_start    = (ev & ST) != 0;
        bus.tx_word_rd  = (ev & RD) != 0;
        bus.tx_end      = (ev & EN) != 0;
        bus.arqn_valid  = (ev & AV) != 0;
        bus.arqn        = (ev & AK) != 0;
        bus.flush       = (ev & FL) != 0;
    endtask

    task automatic check_outs(input string tag, input int s1a, input int req,
                              input int tlen, input int seqn, input int rdy);
        chk({tag, " s1a"},          int'(bus.s1a),          s1a);
        chk({tag, " tx_req"},       int'(bus.tx_req),       req);
        chk({tag, " tx_len"},       int'(bus.tx_len),       tlen);
        chk({tag, " tx_seqn"},      int'(bus.tx_seqn),      seqn);
        chk({tag, " bsm_wr_ready"}, int'(bus.bsm_wr_ready), rdy);
    endtask

    function automatic vec_t mk(input int ev, input int len, input int addr, input int s1a,
                                input int req, input int tlen, input int seqn, input int rdy);
        vec_t v;
        v.ev = ev; v.len = len; v.addr = addr; v.s1a = s1a;
        v.req = req; v.tlen = tlen; v.seqn = seqn; v.rdy = rdy;
        return v;
    endfunction

    // Strobe monitor: each expected read word must show up exactly on its due cycle
    always @(negedge clk_6M) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("lnctrl_cs", int'(bus.lnctrl_cs), 1);
            chk("lnctrl_addr", int'(bus.lnctrl_addr), e.addr);
        end else if (bus.lnctrl_cs) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cs: got cs=1 addr=%0d expected cs=0 (t=%0t)",
                     bus.lnctrl_addr, $time);
        end
    end

    initial begin
        // First packet, len 17 -> 5 words, NAK then retransmit
        tbl.push_back(mk(WD, 17, -1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0,   0, -1, 0, 1, 17, 1, 1));
        tbl.push_back(mk(0,   0, -1, 0, 1, 17, 1, 1));
        tbl.push_back(mk(ST,  0, -1, 0, 1, 17, 1, 1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(RD, 0, (i < 5) ? i : -1, 0, 1, 17, 1, 1));
        tbl.push_back(mk(EN,  0, -1, 0, 0, 17, 1, 1));
        tbl.push_back(mk(AV,  0, -1, 0, 1, 17, 1, 1));
        tbl.push_back(mk(0,   0, -1, 0, 1, 17, 1, 1));
        tbl.push_back(mk(ST,  0, -1, 0, 1, 17, 1, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(RD, 0, i, 0, 1, 17, 1, 1));
        // Other bank filled during TX, then ACK swaps it in
        tbl.push_back(mk(WD, 339, -1, 0, 1, 17, 1, 0));
        tbl.push_back(mk(EN,  0, -1, 0, 0, 17, 1, 0));
        tbl.push_back(mk(AV|AK, 0, -1, 0, 0, 17, 0, 0));
        tbl.push_back(mk(0,   0, -1, 1, 1, 339, 0, 1));
        tbl.push_back(mk(ST,  0, -1, 1, 1, 339, 0, 1));
        for (int i = 0; i < 86; i++) tbl.push_back(mk(RD, 0, (i < 85) ? i : -1, 1, 1, 339, 0, 1));
        tbl.push_back(mk(EN,  0, -1, 1, 0, 339, 0, 1));
        // Flush in WAIT_ARQN with both banks full
        tbl.push_back(mk(WD, 40, -1, 1, 0, 339, 0, 0));
        tbl.push_back(mk(FL,  0, -1, 1, 0, 339, 1, 1));
        tbl.push_back(mk(0,   0, -1, 1, 0, 339, 1, 1));
        // Zero-length packet
        tbl.push_back(mk(WD,  0, -1, 1, 0, 339, 1, 0));
        tbl.push_back(mk(0,   0, -1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(ST,  0, -1, 0, 1, 0, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(RD, 0, -1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(EN,  0, -1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(AV|AK, 0, -1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0,   0, -1, 0, 0, 0, 0, 1));
        // Events that must be ignored in IDLE
        tbl.push_back(mk(AV|AK, 0, -1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(ST|RD, 0, -1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(EN,  0, -1, 0, 0, 0, 0, 1));
        // Simultaneous write-done and ACK, then flush beating a same-cycle write-done
        tbl.push_back(mk(WD,  4, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,   0, -1, 1, 1, 4, 0, 1));
        tbl.push_back(mk(ST,  0, -1, 1, 1, 4, 0, 1));
        tbl.push_back(mk(RD,  0,  0, 1, 1, 4, 0, 1));
        tbl.push_back(mk(EN,  0, -1, 1, 0, 4, 0, 1));
        tbl.push_back(mk(WD|AV|AK, 8, -1, 1, 0, 4, 1, 0));
        tbl.push_back(mk(0,   0, -1, 0, 1, 8, 1, 1));
        tbl.push_back(mk(FL|WD, 5, -1, 0, 0, 8, 0, 1));
        tbl.push_back(mk(0,   0, -1, 0, 0, 8, 0, 1));

        rstz = 1'b0;
        drive(0, 0);
        tick();
        tick();
        check_outs("in_reset", 1, 0, 0, 1, 1);
        chk("in_reset lnctrl_cs", int'(bus.lnctrl_cs), 0);
        chk("in_reset lnctrl_addr", int'(bus.lnctrl_addr), 0);
        rstz = 1'b1;
        tick();
        check_outs("after_reset", 1, 0, 0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ev, tbl[i].len);
            if (tbl[i].addr >= 0) sb.push_back('{addr: tbl[i].addr, due: cyc + 1});
            tick();
            drive(0, 0);
            check_outs($sformatf("row%0d", i), tbl[i].s1a, tbl[i].req, tbl[i].tlen,
                       tbl[i].seqn, tbl[i].rdy);
        end
        tick();
        chk("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset while a read strobe is on the bus
        drive(WD, 12);
        tick();
        drive(0, 0);
        tick();
        check_outs("pre_rst", 1, 1, 12, 0, 1);
        drive(ST, 0);
        tick();
        drive(RD, 0);
        tick();
        drive(0, 0);
        #1;
        chk("pre_rst lnctrl_cs", int'(bus.lnctrl_cs), 1);
        chk("pre_rst lnctrl_addr", int'(bus.lnctrl_addr), 0);
        rstz = 1'b0;
        #1;
        check_outs("async_rst", 1, 0, 0, 1, 1);
        chk("async_rst lnctrl_cs", int'(bus.lnctrl_cs), 0);
        tick();
        rstz = 1'b1;
        tick();
        check_outs("post_rst", 1, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pytxacl_pingpong_ctrl.md
# pytxacl_pingpong_ctrl

Controller for the ping-pong TX ACL payload buffer (two 256x32 single-port SRAM banks). Drives the bank-select `s1a`, so the baseband state machine (bsm) fills one bank while the link controller (lnctrl) transmits the other. Generates lnctrl read addresses and chip selects, and tracks per-bank full state and length. Implements ACL ARQ: it retransmits the same bank with the same SEQN on NAK, and releases the bank, toggles SEQN and swaps on ACK (Vol2 Part B ch 4.5).

## Interface
- No parameters; bank depth fixed at 256 words, payload length 10 bits (bytes).
- clk_6M  in  1  6 MHz clock; only clock in the block.
- rstz  in  1  asynchronous active-low reset.
- bsm_wr_done  in  1  one-cycle pulse: bsm has finished writing the current write bank.
- bsm_wr_len  in  10  payload byte count, sampled with bsm_wr_done.
- bsm_wr_ready  out  1  write bank is empty; bsm may write it.
- s1a  out  1  bank select to datapath. 1 = bsm on bank u0 and lnctrl on u1; 0 = the reverse.
- tx_req  out  1  read bank holds a packet available for transmission.
- tx_len  out  10  byte length of the read-bank packet.
- tx_seqn  out  1  SEQN bit for the read-bank packet.
- tx_start  in  1  pulse: lnctrl begins the payload; clears the word counter.
- tx_word_rd  in  1  pulse: lnctrl requests the next 32-bit word.
- tx_end  in  1  pulse: payload on air is complete.
- arqn_valid  in  1  pulse: ARQN from peer is available.
- arqn  in  1  1 = ACK, 0 = NAK; sampled with arqn_valid.
- flush  in  1  pulse: discard both banks.
- lnctrl_addr  out  8  read word address to datapath.
- lnctrl_cs  out  1  read chip select to datapath; one-cycle pulse per word.

## Operation
- State kept:
  - full[1:0], one flag per bank
  - len0/len1 (10 bits each)
  - seqn register
  - word counter wcnt (9 bits)
  - read-side FSM: IDLE, TX, WAIT_ARQN
- Bank mapping:
  - write bank = s1a ? 0 : 1
  - read bank = s1a ? 1 : 0
- Write completion:
  - bsm_wr_done with the write bank empty sets that bank's full flag and stores bsm_wr_len.
  - bsm_wr_done with the write bank full is ignored.
- Swap: toggle s1a when all of the following hold: write bank full, read bank empty, FSM = IDLE.
  - bsm never writes during a swap, because bsm_wr_ready is low whenever the write bank is full.
- bsm_wr_ready = !full[write bank].
- tx_req = full[read bank] & FSM ≠ WAIT_ARQN.
- tx_len = len[read bank].
- tx_seqn = seqn.
- IDLE → TX on tx_start with tx_req high; wcnt ← 0.
  - tx_start with tx_req low is ignored.
- In TX, tx_word_rd with wcnt < nwords does the following:
  - drives lnctrl_addr = wcnt and lnctrl_cs = 1
  - increments wcnt
  - nwords = (len + 3) >> 2, range 0..256.
- In TX, tx_word_rd with wcnt = nwords is ignored; no cs is issued and wcnt holds.
- TX → WAIT_ARQN on tx_end.
- WAIT_ARQN, on arqn_valid:
  - arqn = 1 (ACK): clear full[read bank], toggle seqn, → IDLE.
  - arqn = 0 (NAK): bank and seqn unchanged, → IDLE. tx_req reasserts and the same packet is retransmitted.
- arqn_valid outside WAIT_ARQN, tx_word_rd outside TX, and tx_end outside TX are ignored.
- flush:
  - clears both full flags and sets FSM → IDLE
  - toggles seqn if full[read bank] was set, so the discarded packet counts as done
  - wins over every same-cycle event.
- Simultaneous bsm_wr_done and ACK: both take effect on the same edge. The swap is evaluated on the following cycle.

## Timing
- All outputs are registered or decoded from registers only. No combinational input-to-output paths.
- Reset values:
  - s1a = 1, seqn = 1 (first ACL packet carries SEQN = 1)
  - full = 00, len0 = len1 = 0, wcnt = 0, FSM = IDLE
  - lnctrl_addr = 0, lnctrl_cs = 0
  - bsm_wr_ready = 1, tx_req = 0, tx_len = 0, tx_seqn = 1
- bsm_wr_done at cycle n:
  - write bank full visible at n+1 (bsm_wr_ready low).
  - If a swap is eligible, s1a toggles at n+2; tx_req and bsm_wr_ready are high at n+2.
- tx_word_rd at cycle n gives lnctrl_cs and lnctrl_addr at n+1. The datapath's output register then holds the word at n+3.
- lnctrl may issue tx_word_rd every cycle, giving one word per cycle sustained.
- ACK at cycle n:
  - full cleared and seqn toggled at n+1.
  - If the write bank is full, swap at n+2 and tx_req high at n+2.
- Asynchronous reset mid-packet immediately returns every register to its reset value.

## Test plan
- Reset, then bsm_wr_done with len = 17:
  - s1a 1→0 two cycles later
  - tx_req = 1, tx_len = 17, tx_seqn = 1, bsm_wr_ready = 1
- tx_start, then 6 tx_word_rd pulses on len = 17:
  - exactly 5 lnctrl_cs pulses with addresses 0,1,2,3,4; the 6th is ignored
- tx_end then NAK:
  - tx_req returns high with seqn = 1 and no swap
  - retransmit reads addresses 0..4 again
- bsm fills the other bank (len = 339) during TX, then ACK:
  - seqn → 0; s1a toggles back to 1
  - tx_len = 339, 85 words readable
- flush during WAIT_ARQN with both banks full:
  - full = 00, tx_req = 0, bsm_wr_ready = 1, seqn toggles
- len = 0 packet:
  - tx_req = 1, no lnctrl_cs generated on any tx_word_rd
  - ACK releases the bank normally
